multicycle_ctl: RTL

- Multi-cycle control FSM for the MIPS-subset processor; replaces the single-cycle main control.
- Sequences a shared-memory datapath (one memory for instructions and data, one ALU, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback.
- Stalls on a memory ready handshake, traps illegal opcodes, and counts retired instructions.

---
 rtl/mctl_pkg.sv | 59 +++++
 rtl/mctl_decode.sv | 68 ++++++
 rtl/multicycle_ctl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mctl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller:
// opcodes, FSM states, datapath mux encodings and the control vector.
package mctl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        RWB,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mctl_decode.sv
// Combinational control-vector decode from the current state; only the
// PC/IR enables look at mem_ready and zero.
module mctl_decode
    import mctl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctl_t   ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_src    = PCSRC_ALU;
                ctl.ir_write  = mem_ready;
                ctl.pc_en     = mem_ready;
            end
            DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH;
                ctl.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctl.iord     = 1'b1;
                ctl.mem_read = 1'b1;
            end
            MEMWB: begin
                ctl.memto_reg = 1'b1;
                ctl.reg_write = 1'b1;
            end
            MEMWR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
            end
            EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_FUNCT;
            end
            RWB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_SUB;
                ctl.pc_src    = PCSRC_ALUOUT;
                ctl.pc_en     = zero;
            end
            JUMP: begin
                ctl.pc_src = PCSRC_JUMP;
                ctl.pc_en  = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctl.sv
// Multi-cycle control FSM for the shared-memory MIPS-subset datapath,
// with sticky illegal-opcode trap and retired-instruction counter.
//
// state  | meaning
// IDLE   | one idle cycle after reset
// FETCH  | read instruction at PC, PC+4 -> PC; waits on mem_ready
// DECODE | op now valid; branch target -> ALUOut
// MEMADR | effective address A + imm
// MEMRD  | load data read at ALUOut; waits on mem_ready
// MEMWB  | MDR -> rt, retire
// MEMWR  | store to ALUOut; waits on mem_ready, retires on completion
// EXEC   | R-type ALU operation
// RWB    | ALUOut -> rd, retire
// BRANCH | compare A/B, PC <- ALUOut if zero, retire
// JUMP   | PC <- jump target, retire
// HALT   | illegal opcode trap, left only by rst
module multicycle_ctl
    import mctl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             memto_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t state_next;
    ctl_t   ctl;
    logic   retire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH:  if (mem_ready) state_next = DECODE;
            DECODE: begin
                if (!op_supported(op))                     state_next = HALT;
                else if (op == OP_LW || op == OP_SW)       state_next = MEMADR;
                else if (op == OP_RTYPE)                   state_next = EXEC;
                else if (op == OP_BEQ)                     state_next = BRANCH;
                else                                       state_next = JUMP;
            end
            MEMADR: state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_next = MEMWB;
            MEMWB: begin
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            EXEC:   state_next = RWB;
            RWB, BRANCH, JUMP: begin
                retire     = 1'b1;
                state_next = FETCH;
            end
            HALT:   state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Set on the edge that enters HALT so it is already high in the first HALT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (state_next == HALT) begin
            illegal <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

    mctl_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctl       (ctl)
    );

    assign pc_en     = ctl.pc_en;
    assign iord      = ctl.iord;
    assign mem_read  = ctl.mem_read;
    assign mem_write = ctl.mem_write;
    assign ir_write  = ctl.ir_write;
    assign reg_dst   = ctl.reg_dst;
    assign memto_reg = ctl.memto_reg;
    assign reg_write = ctl.reg_write;
    assign alu_src_a = ctl.alu_src_a;
    assign alu_src_b = ctl.alu_src_b;
    assign alu_op    = ctl.alu_op;
    assign pc_src    = ctl.pc_src;

endmodule
